aes_v2_invmix_size: RTL and testbench
=====================================

# aes_v2_invmix_size

Lightweight, size-optimised AES (Inv)MixColumns unit for the decrypt side of the v2 AES instruction set. It has a fused AddRoundKey. One GF(2^8) multiply-accumulate datapath is shared across four cycles, producing one output byte per cycle and holding three intermediate bytes. It sits beside the byte-serial SubBytes unit in the AES functional unit and uses the same valid/ready multi-cycle instruction handshake.

## Interface
Parameters:
- none

Ports:
- g_clk     in   1   Single clock; all state updates on the rising edge.
- g_resetn  in   1   Reset, asynchronous, active-low; clears all state immediately.
- valid     in   1   Instruction request; held high, with rs1/rs2/enc stable, until ready.
- rs1       in   32  Column; byte i = rs1[8i+7:8i], with a0 in the LSB.
- rs2       in   32  Round key word; byte i = rs2[8i+7:8i].
- enc       in   1   Set: forward MixColumns. Clear: InvMixColumns.
- ready     out  1   High for exactly one cycle when rd holds the final result.
- rd        out  32  Result; defined only while ready = 1.

## Operation
- Decrypt (enc = 0): rd = InvMixColumns(rs1 ^ rs2).
  - Out_i = 0E·c_i ^ 0B·c_{i+1} ^ 0D·c_{i+2} ^ 09·c_{i+3}.
  - c = rs1 ^ rs2; indices are taken mod 4.
- Encrypt (enc = 1, only when configured): rd = MixColumns(rs1) ^ rs2.
  - Out_i = 02·a_i ^ 03·a_{i+1} ^ a_{i+2} ^ a_{i+3}, then XOR with key byte i.
- GF(2^8) multiplies use the polynomial 0x11B.
  - Built from a single xtime chain (x2, x4, x8) applied to the rotated column.
  - Only one output byte's worth of logic is instantiated.
- FSM: 2-bit counter fsm, states S0..S3. In state Sk, the datapath computes output byte k.
  - S0 with valid: capture byte 0 into b_0; go to S1.
  - S1 with valid: capture b_1; go to S2.
  - S2 with valid: capture b_2; go to S3.
  - S3: ready = 1; rd = {byte3 (combinational), b_2, b_1, b_0}; next state S0 unconditionally.
  - Any state with valid = 0: next state S0. An aborted operation leaves no effect, and b_* need not be cleared.
- Reset (including mid-operation): fsm = S0, b_0/b_1/b_2 = 0, ready = 0 immediately, asynchronously.
- rd while ready = 0 is don't-care but must be X-free after reset.

## Timing
- Latency: 4 cycles. With valid rising in cycle 0 (fsm = S0), ready is high in cycle 3.
  - The consumer samples rd at the clock edge that ends cycle 3.
- ready is a combinational decode of fsm only. There is no combinational path from valid to ready.
- Back-to-back: if valid stays high after the ready cycle, a new operation starts in cycle 4 in S0 with new operands.
- Changing operands while valid is high and ready is low is illegal; the result is unspecified but the FSM still completes.
- Critical path: fsm mux, 8-bit XOR, xtime×3, XOR tree, b_k register.

## Configuration
- AES_V2_INVMIX_FWD_EN defined:
  - enc selects forward MixColumns with a post-XOR of rs2, using the 02/03 coefficient path.
- Not defined:
  - Forward path and enc-dependent muxing are removed.
  - enc is ignored; the block always performs InvMixColumns(rs1 ^ rs2).
- Latency and handshake are identical in both builds.

## Test plan
- Inverse vector: enc = 0, rs1 = 0xbca14d8e, rs2 = 0 held -> ready only in cycle 3, rd = 0x455313db.
- Fused key: enc = 0, rs1 = 0x435eb271, rs2 = 0xffffffff -> rd = 0x455313db in cycle 3.
- Forward (FWD_EN builds only): enc = 1, rs1 = 0x5c220af2, rs2 = 0 -> rd = 0x9d58dc9f. With rs2 = 0x01010101 -> rd = 0x9c59dd9e.
- Identity and back-to-back: rs1 = 0x01010101, rs2 = 0, valid high for 8 cycles -> ready in cycles 3 and 7, rd = 0x01010101 both times (either enc).
- Abort: drop valid in cycle 2, reassert in cycle 4 with rs1 = 0xbca14d8e, enc = 0 -> ready in cycle 7 (not earlier), rd = 0x455313db.
- Async reset: pulse g_resetn low mid-cycle while in S2 -> ready = 0 and fsm = S0 before the next edge; the restarted operation completes in 4 cycles with the correct result.

Source files
------------

// File: rtl/aes_v2_invmix_size.sv
// aes_v2_invmix_size: byte-serial (Inv)MixColumns with fused AddRoundKey, one output byte per cycle.
// Define AES_V2_INVMIX_FWD_EN to add the enc-selected forward MixColumns path.
module aes_v2_invmix_size (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] rd
);
    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
    state_t      fsm, fsm_nxt;
    logic [7:0]  b_0, b_1, b_2, byte_out, inv_byte;
    logic [31:0] col, rot;
    logic [7:0]  x1 [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
`ifdef AES_V2_INVMIX_FWD_EN
    logic [7:0] fwd_byte;
    assign col = enc ? rs1 : rs1 ^ rs2;
`else
    logic unused_enc;
    assign unused_enc = enc;
    assign col = rs1 ^ rs2;
`endif
    // rotate so that lane 0 always holds c_k for the byte being produced
    assign rot = fsm == S0 ? col :
                 fsm == S1 ? {col[7:0],  col[31:8]}  :
                 fsm == S2 ? {col[15:0], col[31:16]} :
                             {col[23:0], col[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign x1[i] = rot[8*i +: 8];
        assign x2[i] = xt(x1[i]);
        assign x4[i] = xt(x2[i]);
        assign x8[i] = xt(x4[i]);
    end
    assign inv_byte = (x8[0] ^ x4[0] ^ x2[0]) ^ (x8[1] ^ x2[1] ^ x1[1]) ^
                      (x8[2] ^ x4[2] ^ x1[2]) ^ (x8[3] ^ x1[3]);
`ifdef AES_V2_INVMIX_FWD_EN
    assign fwd_byte = x2[0] ^ x2[1] ^ x1[1] ^ x1[2] ^ x1[3] ^ rs2[{fsm, 3'b000} +: 8];
    assign byte_out = enc ? fwd_byte : inv_byte;
`else
    assign byte_out = inv_byte;
`endif
    always_comb begin
        fsm_nxt = S0;
        if (valid)
            fsm_nxt = fsm == S0 ? S1 : fsm == S1 ? S2 : fsm == S2 ? S3 : S0;
    end
    assign ready = fsm == S3;
    assign rd    = ready ? {byte_out, b_2, b_1, b_0} : 32'h0;
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fsm <= S0;
            b_0 <= 8'h00;
            b_1 <= 8'h00;
            b_2 <= 8'h00;
        end else begin
            fsm <= fsm_nxt;
            if (valid && fsm == S0) b_0 <= byte_out;
            if (valid && fsm == S1) b_1 <= byte_out;
            if (valid && fsm == S2) b_2 <= byte_out;
        end
    end
endmodule

// File: tb/tb_aes_v2_invmix_size.sv
// tb_aes_v2_invmix_size: directed vector table plus abort and async-reset sequences.
module tb_aes_v2_invmix_size;
    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        enc = 1'b0;
    logic        ready;
    logic [31:0] rd;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        enc;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[$];

    aes_v2_invmix_size dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid),
        .rs1(rs1), .rs2(rs2), .enc(enc), .ready(ready), .rd(rd)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Drive one operation starting in the current cycle (fsm expected S0);
    // checks ready in each of cycles 0..3 and rd in cycle 3, returns #1 after the final edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] k, input logic e, input logic [31:0] exp, input string name);
        valid = 1'b1; rs1 = a; rs2 = k; enc = e;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("%s ready c%0d", name, c), {31'h0, ready}, {31'h0, c == 3});
            if (c == 3) chk({name, " rd"}, rd, exp);
            @(posedge g_clk); #1;
        end
    endtask

    initial begin
        vt.push_back('{32'hbca14d8e, 32'h00000000, 1'b0, 32'h455313db});
        vt.push_back('{32'h435eb271, 32'hffffffff, 1'b0, 32'h455313db});
        vt.push_back('{32'h9d58dc9f, 32'h00000000, 1'b0, 32'h5c220af2});
        vt.push_back('{32'h8f6c8ae7, 32'h12345678, 1'b0, 32'h5c220af2});
        vt.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'h00000000});
        vt.push_back('{32'hc6c6c6c6, 32'h00000000, 1'b0, 32'hc6c6c6c6});
        vt.push_back('{32'h01010101, 32'h00000000, 1'b0, 32'h01010101});
        vt.push_back('{32'h01010101, 32'h00000000, 1'b0, 32'h01010101});
        vt.push_back('{32'h01010101, 32'h00000000, 1'b1, 32'h01010101});
        vt.push_back('{32'h01010101, 32'h00000000, 1'b1, 32'h01010101});
`ifdef AES_V2_INVMIX_FWD_EN
        vt.push_back('{32'h5c220af2, 32'h00000000, 1'b1, 32'h9d58dc9f});
        vt.push_back('{32'h5c220af2, 32'h01010101, 1'b1, 32'h9c59dd9e});
`else
        vt.push_back('{32'hbca14d8e, 32'h00000000, 1'b1, 32'h455313db});
`endif
        repeat (2) @(posedge g_clk);
        #1;
        chk("reset ready", {31'h0, ready}, 32'h0);
        chk("reset rd known", {31'h0, $isunknown(rd)}, 32'h0);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        chk("idle ready", {31'h0, ready}, 32'h0);
        // valid held throughout the table: operations run back to back
        for (int v = 0; v < vt.size(); v++)
            run_op(vt[v].rs1, vt[v].rs2, vt[v].enc, vt[v].exp, $sformatf("vec%0d", v));
        valid = 1'b0;
        @(posedge g_clk); #1;

        // abort: valid dropped in cycle 2, reasserted in cycle 4
        valid = 1'b1; rs1 = 32'h01010101; rs2 = 32'h0; enc = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) valid = 1'b0;
            #1;
            chk($sformatf("abort ready c%0d", c), {31'h0, ready}, 32'h0);
            @(posedge g_clk); #1;
        end
        run_op(32'hbca14d8e, 32'h0, 1'b0, 32'h455313db, "after abort");
        valid = 1'b0;
        @(posedge g_clk); #1;

        // async reset mid-cycle while in S2
        valid = 1'b1; rs1 = 32'h435eb271; rs2 = 32'hffffffff; enc = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        chk("pre-reset fsm", {30'h0, dut.fsm}, 32'd2);
        #2 g_resetn = 1'b0;
        #1;
        chk("async ready", {31'h0, ready}, 32'h0);
        chk("async fsm", {30'h0, dut.fsm}, 32'd0);
        chk("async b_0", {24'h0, dut.b_0}, 32'h0);
        #1 g_resetn = 1'b1;
        run_op(32'h435eb271, 32'hffffffff, 1'b0, 32'h455313db, "after reset");
        valid = 1'b0;
        @(posedge g_clk); #1;
        chk("final idle ready", {31'h0, ready}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end
endmodule
